crcu_chan_ctrl: RTL
===================

CRCU_CHAN_CTRL -- requirements
Module: crcu_chan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8, number of clock/reset channels (legal 1..16).
REQ-002 Parameter SEQ_GAP, default 16, cycles between successive channel releases in the power-on sequence (legal 1..255).
REQ-003 PCLK  input  1  sole clock; all state on rising edge.
REQ-004 PRESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-006 PADDR  input  32  APB address; only [7:0] decoded.
REQ-007 PWDATA  input  32  APB write data.
REQ-008 PRDATA  output  32  APB read data.
REQ-009 PREADY  output  1  tied 1; zero-wait slave.
REQ-010 PSLVERR  output  1  access-phase error.
REQ-011 ch_clk_en  output  NUM_CH  per-channel divided clock-enable pulse.
REQ-012 ch_rst_n  output  NUM_CH  per-channel active-low reset.

Function
REQ-013 Access phase = PSEL&PENABLE; write commits on the PCLK edge ending the access phase.
REQ-014 CTRL[k] at PADDR[7:0]=4*k for k<NUM_CH: bit0 EN, bit1 RST_REQ (write-1 trigger, reads 0), [15:8] DIV, [23:16] HOLD; other bits read 0.
REQ-015 STATUS at 0x40, read-only: bit k = ~ch_rst_n[k], bit31 = SEQ_DONE, others 0.
REQ-016 PSLVERR=1 in access phase for PADDR[1:0]!=0, unmapped address, or write to STATUS; such writes have no effect; PRDATA=0 for unmapped reads.
REQ-017 PRDATA valid combinationally during access phase; 0 when not in access phase.
REQ-018 Divider k: EN=0 -> counter held 0, ch_clk_en[k]=0.
REQ-019 EN=1 -> counter counts 0..DIV and wraps to 0; ch_clk_en[k]=1 exactly when counter==DIV (one pulse per DIV+1 cycles; DIV=0 -> constant 1).
REQ-020 Any write to CTRL[k] clears divider k counter to 0 on the commit edge; first pulse DIV+1 cycles after commit.
REQ-021 Divider keeps running while ch_rst_n[k]=0.
REQ-022 Per-channel reset FSM states: OFF (waiting for sequencer, rst_n=0), RUN (rst_n=1), HOLD (rst_n=0).
REQ-023 OFF->RUN when sequencer releases channel k.
REQ-024 RUN->HOLD on RST_REQ write; hold counter loads HOLD from same write; ch_rst_n[k]=0 from next cycle for HOLD+1 cycles, then HOLD->RUN.
REQ-025 RST_REQ written while in HOLD restarts hold count with newly written HOLD (retrigger).
REQ-026 RST_REQ written while in OFF is ignored; other CTRL fields still update.
REQ-027 Sequencer: after reset release, counts cycles; channel k released when count reaches (k+1)*SEQ_GAP; after channel NUM_CH-1 released, SEQ_DONE=1 and count stops (no wrap).
REQ-028 Channels released strictly in ascending order, one per SEQ_GAP; never two on the same cycle.

Reset
REQ-029 PRESETN low: all CTRL = 0x000F_0001 (EN=1, DIV=0, HOLD=15), dividers 0, FSMs OFF, sequencer count 0, SEQ_DONE=0.
REQ-030 During reset: ch_rst_n=0, ch_clk_en=0, PRDATA=0, PSLVERR=0, PREADY=1.
REQ-031 ch_clk_en follows REQ-019 from first edge after PRESETN deassertion; ch_rst_n stays 0 until sequencer release.
REQ-032 PRESETN asserted mid-operation (any HOLD or sequencing) returns all state to REQ-029 values immediately.

Verification
REQ-033 NUM_CH=4, SEQ_GAP=16, release PRESETN -> ch_rst_n[0..3] rise at cycles 16/32/48/64; STATUS read after 64 = 0x8000_0000.
REQ-034 Write CTRL[1]=0x0000_0301 (DIV=3) -> ch_clk_en[1] pulses 1 cycle in every 4, first pulse 4 cycles after commit; EN=0 -> pulses stop next cycle.
REQ-035 After SEQ_DONE write CTRL[2]=0x0004_0003 -> ch_rst_n[2] low exactly 5 cycles, STATUS bit2=1 meanwhile; rewrite RST_REQ at HOLD cycle 3 -> low extends 5 cycles from retrigger.
REQ-036 Read 0x44, read 0x02, write 0x40 -> PSLVERR=1 each, PRDATA=0, no register change.
REQ-037 RST_REQ to channel 3 at cycle 20 (still OFF) -> ignored, release at 64 unchanged; PRESETN pulse during a HOLD -> all outputs to reset values, sequence restarts.

Source files
------------

// File: rtl/crcu_chan_ctrl.sv
// Clock/reset channel controller: APB-programmed clock-enable dividers, per-channel
// reset FSMs with retriggerable hold pulses, and an ordered power-on release sequencer.
module crcu_chan_ctrl #(
    parameter int NUM_CH  = 8,
    parameter int SEQ_GAP = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic [NUM_CH-1:0] ch_rst_n
);

    localparam int          SEQ_MAX     = NUM_CH * SEQ_GAP;
    localparam int          CW          = $clog2(SEQ_MAX + 1);
    localparam logic [7:0]  STATUS_ADDR = 8'h40;
    localparam logic [31:0] CTRL_LIMIT  = 32'(4 * NUM_CH);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_t;

    logic [7:0]              addr_s;
    logic                    access_s;
    logic                    ctrl_hit_s;
    logic                    status_hit_s;
    logic                    err_s;
    logic                    wr_ok_s;
    logic                    rd_ok_s;
    logic [NUM_CH-1:0]       sel_s;
    logic [NUM_CH-1:0]       wr_s;
    logic [NUM_CH-1:0]       rst_req_s;
    logic [NUM_CH-1:0]       rel_s;
    logic [NUM_CH-1:0]       in_rst_s;
    logic [NUM_CH-1:0][31:0] ctrl_rd_s;
    logic [31:0]             ctrl_mux_s;
    logic [31:0]             status_s;
    logic [CW-1:0]           seq_cnt_r;
    logic [CW-1:0]           seq_inc_s;
    logic                    seq_done_r;
    logic                    unused_s;

    assign addr_s       = PADDR[7:0];
    assign access_s     = PSEL & PENABLE & PRESETN;
    assign ctrl_hit_s   = (addr_s[1:0] == 2'b00) && ({24'd0, addr_s} < CTRL_LIMIT);
    assign status_hit_s = (addr_s == STATUS_ADDR);
    assign err_s        = access_s & ((addr_s[1:0] != 2'b00) | ~(ctrl_hit_s | status_hit_s)
                                      | (status_hit_s & PWRITE));
    assign wr_ok_s      = access_s & PWRITE & ctrl_hit_s;
    assign rd_ok_s      = access_s & ~PWRITE & ~err_s;
    assign seq_inc_s    = seq_cnt_r + CW'(1);
    assign in_rst_s     = ~ch_rst_n;
    assign status_s     = {seq_done_r, 31'(in_rst_s)};
    assign unused_s     = ^{PADDR[31:8], PWDATA[31:24], PWDATA[7:2]};

    assign PREADY  = 1'b1;
    assign PSLVERR = err_s;
    assign PRDATA  = rd_ok_s ? (status_hit_s ? status_s : ctrl_mux_s) : 32'd0;

    // One-hot select of the addressed CTRL register for readback.
    always_comb begin
        ctrl_mux_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctrl_mux_s = ctrl_mux_s | (ctrl_rd_s[i] & {32{sel_s[i]}});
        end
    end

    // Power-on sequencer: free count that freezes once the last channel is released.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            seq_cnt_r  <= '0;
            seq_done_r <= 1'b0;
        end else if (!seq_done_r) begin
            seq_cnt_r  <= seq_inc_s;
            seq_done_r <= rel_s[NUM_CH-1];
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic       en_r;
        logic       en_nx_s;
        logic       clk_en_r;
        logic       rst_n_r;
        logic [7:0] div_r;
        logic [7:0] div_nx_s;
        logic [7:0] hold_r;
        logic [7:0] cnt_r;
        logic [7:0] cnt_nx_s;
        logic [7:0] hcnt_r;
        ch_state_t  state_r;

        assign sel_s[k]     = (addr_s[7:2] == 6'(k));
        assign wr_s[k]      = wr_ok_s & sel_s[k];
        assign rst_req_s[k] = wr_s[k] & PWDATA[1];
        assign rel_s[k]     = ~seq_done_r & (seq_inc_s == CW'((k + 1) * SEQ_GAP));
        assign ctrl_rd_s[k] = {8'd0, hold_r, div_r, 7'd0, en_r};
        assign ch_clk_en[k] = clk_en_r;
        assign ch_rst_n[k]  = rst_n_r;

        // Next divider state; the pulse is registered from these so it lines up with the count.
        always_comb begin
            en_nx_s  = en_r;
            div_nx_s = div_r;
            cnt_nx_s = 8'd0;
            if (wr_s[k]) begin
                en_nx_s  = PWDATA[0];
                div_nx_s = PWDATA[15:8];
                cnt_nx_s = 8'd0;
            end else if (en_r && (cnt_r != div_r)) begin
                cnt_nx_s = cnt_r + 8'd1;
            end else begin
                cnt_nx_s = 8'd0;
            end
        end

        // CTRL fields and divider counter.
        always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
                en_r     <= 1'b1;
                div_r    <= 8'd0;
                hold_r   <= 8'd15;
                cnt_r    <= 8'd0;
                clk_en_r <= 1'b0;
            end else begin
                en_r     <= en_nx_s;
                div_r    <= div_nx_s;
                hold_r   <= wr_s[k] ? PWDATA[23:16] : hold_r;
                cnt_r    <= cnt_nx_s;
                clk_en_r <= en_nx_s & (cnt_nx_s == div_nx_s);
            end
        end

        // Reset FSM: a write in HOLD reloads the count, so retrigger wins over expiry.
        always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
                state_r <= ST_OFF;
                hcnt_r  <= 8'd0;
                rst_n_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_OFF: begin
                        if (rel_s[k]) begin
                            state_r <= ST_RUN;
                            rst_n_r <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (rst_req_s[k]) begin
                            state_r <= ST_HOLD;
                            hcnt_r  <= PWDATA[23:16];
                            rst_n_r <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (rst_req_s[k]) begin
                            hcnt_r <= PWDATA[23:16];
                        end else if (hcnt_r == 8'd0) begin
                            state_r <= ST_RUN;
                            rst_n_r <= 1'b1;
                        end else begin
                            hcnt_r <= hcnt_r - 8'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_OFF;
                        rst_n_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
